// File: rtl/wishbone_interconnect_n.sv
// wishbone_interconnect_n: one Wishbone classic master to N slaves.
// Each slave owns an equal address window of 2**SPAN_LOG2 bytes. The slave
// index is decoded in IDLE and held in sel until the cycle ends. Unmapped
// addresses and slaves that do not acknowledge in time get a one-cycle bus
// error. A saturating counter records every error response.
// Ports:
//   clk_i, rst_n_i                          clock, async active-low reset
//   adr/dat/cyc/stb/we_o_master (in)        master request
//   ack/err/dat_i_master (out)              master response
//   adr/dat/we_o_out (out)                  broadcast to all slaves
//   cyc_o_out, stb_o_out (out, N_SLAVES)    per-slave cycle/strobe
//   ack_i_in (in, N_SLAVES)                 per-slave acknowledge
//   dat_i_in (in, N_SLAVES*DATA_WIDTH)      per-slave read data
//   busy_o (out)                            state != IDLE
//   err_cnt_o (out, ERR_CNT_WIDTH)          saturating error count
module wishbone_interconnect_n #(
    parameter int unsigned N_SLAVES       = 4,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned SPAN_LOG2      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned ERR_CNT_WIDTH  = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [ADDR_WIDTH-1:0]          adr_o_master,
    input  logic [DATA_WIDTH-1:0]          dat_o_master,
    input  logic                           cyc_o_master,
    input  logic                           stb_o_master,
    input  logic                           we_o_master,
    output logic                           ack_i_master,
    output logic                           err_i_master,
    output logic [DATA_WIDTH-1:0]          dat_i_master,
    output logic [ADDR_WIDTH-1:0]          adr_o_out,
    output logic [DATA_WIDTH-1:0]          dat_o_out,
    output logic                           we_o_out,
    output logic [N_SLAVES-1:0]            cyc_o_out,
    output logic [N_SLAVES-1:0]            stb_o_out,
    input  logic [N_SLAVES-1:0]            ack_i_in,
    input  logic [N_SLAVES*DATA_WIDTH-1:0] dat_i_in,
    output logic                           busy_o,
    output logic [ERR_CNT_WIDTH-1:0]       err_cnt_o
);

    localparam int unsigned SEL_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERROR  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state, state_nxt;
    logic [SEL_W-1:0]        sel;
    logic [TO_W-1:0]         to_cnt;
    logic [ERR_CNT_WIDTH-1:0] err_cnt;

    logic [ADDR_WIDTH-1:0]   idx_c;
    logic                    mapped_c;
    logic                    req_c;
    logic                    ack_sel_c;
    logic [DATA_WIDTH-1:0]   dat_sel_c;
    logic                    to_hit_c;

    // Broadcast signals follow the master directly.
    assign adr_o_out = adr_o_master;
    assign dat_o_out = dat_o_master;
    assign we_o_out  = we_o_master;

    // Full-width compare so any set upper address bit counts as unmapped.
    assign idx_c    = adr_o_master >> SPAN_LOG2;
    assign mapped_c = (idx_c < ADDR_WIDTH'(N_SLAVES));
    assign req_c    = cyc_o_master & stb_o_master;

    // Last ACTIVE cycle allowed before the timeout fires.
    assign to_hit_c = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // Select the latched slave's ack and read data.
    always_comb begin
        ack_sel_c = 1'b0;
        dat_sel_c = '0;
        for (int unsigned i = 0; i < N_SLAVES; i++) begin
            if (sel == SEL_W'(i)) begin
                ack_sel_c = ack_i_in[i];
                dat_sel_c = dat_i_in[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (req_c) begin
                    state_nxt = mapped_c ? ACTIVE : ERROR;
                end
            end
            ACTIVE: begin
                if (!req_c) begin
                    state_nxt = IDLE;
                end else if (ack_sel_c) begin
                    state_nxt = DONE;
                end else if (to_hit_c) begin
                    state_nxt = ERROR;
                end
            end
            ERROR:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs; a strobe without cyc is meaningless, so stb is gated by cyc.
    always_comb begin
        cyc_o_out    = '0;
        stb_o_out    = '0;
        ack_i_master = 1'b0;
        err_i_master = 1'b0;
        dat_i_master = '0;
        busy_o       = (state != IDLE);
        unique case (state)
            ACTIVE: begin
                for (int unsigned i = 0; i < N_SLAVES; i++) begin
                    if (sel == SEL_W'(i)) begin
                        cyc_o_out[i] = cyc_o_master;
                        stb_o_out[i] = stb_o_master & cyc_o_master;
                    end
                end
                ack_i_master = req_c & ack_sel_c;
                dat_i_master = (req_c & ack_sel_c) ? dat_sel_c : '0;
            end
            ERROR:   err_i_master = 1'b1;
            default: ;
        endcase
    end

    // Slave latch, timeout counter and error counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sel     <= '0;
            to_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (state == IDLE && req_c && mapped_c) begin
                sel    <= SEL_W'(idx_c);
                to_cnt <= '0;
            end
            if (state == ACTIVE && req_c && !ack_sel_c) begin
                to_cnt <= to_cnt + TO_W'(1);
            end
            if (state == ERROR && err_cnt != '1) begin
                err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
            end
        end
    end

    assign err_cnt_o = err_cnt;

endmodule
